// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and the vblank arbiter state encoding.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int H_TOTAL      = 800;

  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int V_TOTAL      = 525;

  typedef enum logic [1:0] {
    S_CLOSED = 2'd0,
    S_IDLE   = 2'd1,
    S_GRANT  = 2'd2,
    S_GAP    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/vblank_arbiter_rr_pick.sv
// Round-robin selector: first set request at or above ptr, with wrap.
// Latency: combinational. Backpressure: none, pure function of req/ptr.
// Valid is low when no request is pending.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/vblank_arbiter.sv
// Grants the board-state resource only during vertical blanking, round-robin, plus frame tick.
// Latency: grant 1 cycle after req seen in idle; 2-cycle minimum spacing. Backpressure: req held until gnt.
// Optional MAX_HOLD timeout revoke enabled by defining VBLANK_ARB_TIMEOUT_EN.
module vblank_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int MAX_HOLD = 64
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [9:0]         x_count,
  input  logic [9:0]         y_count,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               abort,
  output logic               window_open,
  output logic               frame_tick
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // A hold limit at or above one line could overrun the guard line into active video.
  if (NUM_REQ < 1 || NUM_REQ > 4 || MAX_HOLD < 1 || MAX_HOLD >= H_TOTAL ||
      V_ACTIVE >= V_TOTAL - 1) begin : g_bad_cfg
    $error("vblank_arbiter: illegal parameter combination");
  end

  arb_state_t           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        owner;
  logic [PW-1:0]        next_ptr;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [PW-1:0]        pick_idx;
  logic                 pick_vld;
  logic                 open;
  logic                 owner_done;
  logic                 hold_expired;

  assign open       = (y_count >= 10'(V_ACTIVE)) && (y_count != 10'(V_TOTAL - 1));
  assign owner_done = done[owner];
  assign next_ptr   = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef VBLANK_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_cnt;
  assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
`endif

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_CLOSED;
      gnt         <= '0;
      abort       <= 1'b0;
      window_open <= 1'b0;
      frame_tick  <= 1'b0;
      ptr         <= '0;
      owner       <= '0;
`ifdef VBLANK_ARB_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      window_open <= open;
      frame_tick  <= (x_count == 10'd0) && (y_count == 10'(V_ACTIVE));
      abort       <= 1'b0;
      case (state)
        S_CLOSED: if (open) state <= S_IDLE;
        S_IDLE: begin
          if (!open) begin
            state <= S_CLOSED;
          end else if (pick_vld) begin
            gnt   <= pick_oh;
            owner <= pick_idx;
            state <= S_GRANT;
`ifdef VBLANK_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        S_GRANT: begin
`ifdef VBLANK_ARB_TIMEOUT_EN
          if (hold_cnt != HOLD_W'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
`endif
          // A done that coincides with a forced release wins: no abort.
          if (owner_done) begin
            gnt   <= '0;
            ptr   <= next_ptr;
            state <= S_GAP;
          end else if (!open || hold_expired) begin
            gnt   <= '0;
            abort <= 1'b1;
            ptr   <= next_ptr;
            state <= S_GAP;
          end
        end
        S_GAP:   state <= open ? S_IDLE : S_CLOSED;
        default: state <= S_CLOSED;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_arbiter.sv
// Directed bench for vblank_arbiter with hand-computed expectations (default NUM_REQ=2, MAX_HOLD=64).
module tb_vblank_arbiter;

  logic       pixel_clk;
  logic       rst_n;
  logic [9:0] x_count;
  logic [9:0] y_count;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] gnt;
  logic       abort;
  logic       window_open;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  vblank_arbiter dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .x_count     (x_count),
    .y_count     (y_count),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .abort       (abort),
    .window_open (window_open),
    .frame_tick  (frame_tick)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; done = 2'b00; x_count = 10'd0; y_count = 10'd100;
    #3;
    check("reset_gnt", {6'd0, gnt}, 8'h00);
    check("reset_abort", {7'd0, abort}, 8'h00);
    check("reset_window", {7'd0, window_open}, 8'h00);
    check("reset_tick", {7'd0, frame_tick}, 8'h00);
    #9 rst_n = 1'b1;

    // Active video: no grant despite requests.
    req = 2'b11; x_count = 10'd5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("active_gnt", {6'd0, gnt}, 8'h00);
    end
    check("active_window", {7'd0, window_open}, 8'h00);

    // Start of blanking.
    x_count = 10'd0; y_count = 10'd480;
    tick();
    check("blank_tick", {7'd0, frame_tick}, 8'h01);
    check("blank_window", {7'd0, window_open}, 8'h01);
    check("blank_gnt_idle", {6'd0, gnt}, 8'h00);
    x_count = 10'd1;
    tick();
    check("first_gnt", {6'd0, gnt}, 8'h01);
    check("tick_single", {7'd0, frame_tick}, 8'h00);

    // Round robin: owner 0 releases after 5 cycles.
    for (int i = 0; i < 4; i++) tick();
    check("own0_hold", {6'd0, gnt}, 8'h01);
    done = 2'b01;
    tick();
    done = 2'b00;
    check("rel0_gnt", {6'd0, gnt}, 8'h00);
    check("rel0_abort", {7'd0, abort}, 8'h00);
    tick();
    check("gap0_gnt", {6'd0, gnt}, 8'h00);
    tick();
    check("rr_gnt1", {6'd0, gnt}, 8'h02);
    done = 2'b01;
    tick();
    done = 2'b00;
    check("nonowner_done", {6'd0, gnt}, 8'h02);
    done = 2'b10;
    tick();
    done = 2'b00;
    check("rel1_gnt", {6'd0, gnt}, 8'h00);
    check("rel1_abort", {7'd0, abort}, 8'h00);
    tick();
    tick();
    check("rr_gnt0", {6'd0, gnt}, 8'h01);

    // Hold-length behaviour with only requester 0 active.
    req = 2'b01;
    for (int i = 0; i < 63; i++) tick();
    check("hold64_gnt", {6'd0, gnt}, 8'h01);
`ifdef VBLANK_ARB_TIMEOUT_EN
    tick();
    check("timeout_gnt", {6'd0, gnt}, 8'h00);
    check("timeout_abort", {7'd0, abort}, 8'h01);
    tick();
    check("timeout_abort_1cyc", {7'd0, abort}, 8'h00);
    tick();
    check("timeout_regrant", {6'd0, gnt}, 8'h01);
    for (int i = 0; i < 63; i++) tick();
    done = 2'b01;
    tick();
    done = 2'b00;
    check("done_timeout_gnt", {6'd0, gnt}, 8'h00);
    check("done_timeout_abort", {7'd0, abort}, 8'h00);
`else
    tick();
    check("no_timeout_gnt", {6'd0, gnt}, 8'h01);
    check("no_timeout_abort", {7'd0, abort}, 8'h00);
    done = 2'b01;
    tick();
    done = 2'b00;
    check("late_done_gnt", {6'd0, gnt}, 8'h00);
    check("late_done_abort", {7'd0, abort}, 8'h00);
`endif

    // Window close: grant late on line 523, revoked on the guard line.
    req = 2'b00;
    tick();
    tick();
    y_count = 10'd523; x_count = 10'd790; req = 2'b01;
    tick();
    check("late_gnt", {6'd0, gnt}, 8'h01);
    for (int i = 791; i < 800; i++) begin
      x_count = 10'(i);
      tick();
    end
    check("late_gnt_hold", {6'd0, gnt}, 8'h01);
    y_count = 10'd524; x_count = 10'd0;
    tick();
    check("close_gnt", {6'd0, gnt}, 8'h00);
    check("close_abort", {7'd0, abort}, 8'h01);
    check("close_window", {7'd0, window_open}, 8'h00);
    tick();
    check("close_abort_1cyc", {7'd0, abort}, 8'h00);
    y_count = 10'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("line0_gnt", {6'd0, gnt}, 8'h00);
    end
    y_count = 10'd479; x_count = 10'd799;
    tick();
    check("line479_gnt", {6'd0, gnt}, 8'h00);
    check("line479_window", {7'd0, window_open}, 8'h00);

    // Next frame, then reset in the middle of a grant.
    y_count = 10'd480; x_count = 10'd0;
    tick();
    check("frame2_tick", {7'd0, frame_tick}, 8'h01);
    x_count = 10'd1;
    tick();
    check("frame2_gnt", {6'd0, gnt}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", {6'd0, gnt}, 8'h00);
    check("arst_abort", {7'd0, abort}, 8'h00);
    check("arst_window", {7'd0, window_open}, 8'h00);
    check("arst_tick", {7'd0, frame_tick}, 8'h00);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_closed", {6'd0, gnt}, 8'h00);
    tick();
    check("post_rst_gnt", {6'd0, gnt}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vblank_arbiter.md
Name: vblank_arbiter

Overview:
- Shares the board-state/register resource between game-logic requesters. Access is granted only during vertical blanking, so the pixel renderer has exclusive use of the resource during active video.
- Takes the VGA timing counters as inputs and runs a round-robin grant FSM, with a bounded hold time and a forced release before the next frame starts.
- Also generates a one-cycle frame tick that the game logic uses for scheduling.

Parameters:
- NUM_REQ, 2, number of requesters (1..4).
- V_ACTIVE, 480, first blanking line.
- V_TOTAL, 525, lines per frame.
- H_TOTAL, 800, pixels per line.
- MAX_HOLD, 64, maximum grant length in cycles (1..H_TOTAL-1).

Ports:
- pixel_clk  in  1  pixel clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_count  in  10  horizontal counter from the timing generator.
- y_count  in  10  vertical counter from the timing generator.
- req  in  NUM_REQ  level request, one bit per requester; held until granted.
- done  in  NUM_REQ  one-cycle release pulse from the current owner.
- gnt  out  NUM_REQ  one-hot grant, registered.
- abort  out  1  one-cycle pulse when a grant is revoked by the arbiter.
- window_open  out  1  registered; 1 while new grants may be issued.
- frame_tick  out  1  one-cycle pulse at the start of blanking.

Behaviour:
- Reset: gnt=0, abort=0, window_open=0, frame_tick=0, FSM=S_CLOSED, RR pointer=0, hold counter=0. Reset asserted mid-grant drops gnt immediately (asynchronously).
- Window condition (combinational, internal): open = (y_count >= V_ACTIVE) && (y_count != V_TOTAL-1). The last line is a guard line; MAX_HOLD < H_TOTAL guarantees release before line 0. window_open is the registered version of this condition.
- frame_tick: asserted the cycle after pixel_clk samples x_count==0 && y_count==V_ACTIVE. Exactly one pulse per frame.
- FSM states: S_CLOSED, S_IDLE, S_GRANT, S_GAP.
  - S_CLOSED -> S_IDLE when open.
  - S_IDLE: if !open -> S_CLOSED. Else, if any req bit is set, pick the first set bit searching from the RR pointer upward with wrap. Set that gnt bit, clear the hold counter, go to S_GRANT. Grant latency is 1 cycle after req is sampled in S_IDLE.
  - S_GRANT:
    - done[owner] -> gnt=0, RR pointer=owner+1 (mod NUM_REQ), go to S_GAP.
    - Forced release (no done in that cycle) when !open or the hold counter reaches MAX_HOLD-1 -> gnt=0, abort=1 for one cycle, RR pointer advances, go to S_GAP.
    - If done and a forced-release condition occur in the same cycle, it is a normal release: no abort.
    - done bits from non-owners are ignored.
  - S_GAP: one dead cycle with gnt=0. Then go to S_IDLE if open, else S_CLOSED. Back-to-back grants are therefore spaced at least 2 cycles apart.
- Hold counter: ceil(log2(MAX_HOLD+1)) bits. Increments every cycle in S_GRANT and saturates, never wraps.
- req deasserted while granted has no effect; only done or a forced release ends a grant.
- A max-length grant always ends no later than the last cycle of line V_TOTAL-1. gnt is never 1 while y_count < V_ACTIVE.

Optional Feature:
- Macro: VBLANK_ARB_TIMEOUT_EN.
- Defined: MAX_HOLD timeout revoke with abort, as described above.
- Undefined: no hold counter. A grant persists until done or until the window closes; the window-close revoke still pulses abort.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL, sync positions);
  - FSM state encoding (2-bit localparams S_CLOSED/S_IDLE/S_GRANT/S_GAP).
- One natural sub-module: rr_pick, a combinational round-robin selector (req, pointer -> one-hot, valid).

Test Plan:
- Reset mid-grant: assert rst_n=0 while gnt=2'b01 -> gnt, abort, window_open and frame_tick all 0 immediately; after release, FSM resumes at S_CLOSED.
- No grant in active video: hold req=2'b11 at y=100 -> gnt stays 0. Step to x=0, y=480 -> frame_tick one cycle later, window_open=1, gnt=2'b01 one cycle after S_IDLE is entered.
- Round robin: req=2'b11, owner 0 pulses done after 5 cycles -> gnt=0 for 1 gap cycle, then gnt=2'b10. After owner 1's done -> gnt=2'b01.
- Timeout (macro defined): req=2'b01 held, no done -> gnt drops after exactly 64 cycles with abort=1 for one cycle; regrant follows after the gap.
- Window close: grant issued at y=523, x=790 with no done -> forced release as y reaches 524, abort=1, and gnt=0 for all of y=0..479.
- Simultaneous done and timeout on cycle 64 -> gnt=0, abort=0. A done pulse on a non-owner bit -> ignored, gnt unchanged.
